// File: rtl/conv_1st_collect_pkg.sv
// conv_1st_collect_pkg: shared first-layer conv defaults, field widths and serializer states
package conv_1st_collect_pkg;
  localparam int LANES_DEF = 4;
  localparam int DW_DEF    = 20;
  localparam int OW_DEF    = 8;
  localparam int DEPTH_DEF = 4;
  localparam int CH_W      = 5;
  localparam int POS_W     = 10;
  typedef enum logic {S_IDLE, S_SEND} ser_state_e;
endpackage

// File: rtl/conv_1st_res_fifo.sv
// conv_1st_res_fifo: result-set capture FIFO; push when not full, pop when not empty
module conv_1st_res_fifo #(
  parameter int W     = 8,
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     push_i,
  input  logic                     pop_i,
  input  logic [W-1:0]             wdata_i,
  output logic [W-1:0]             rdata_o,
  output logic [$clog2(DEPTH):0]   count_o,
  output logic                     full_o,
  output logic                     empty_o
);
  localparam int AW = $clog2(DEPTH);
  logic [W-1:0]  mem_q [DEPTH];
  logic [AW-1:0] wr_q, rd_q;
  logic [AW:0]   cnt_q;
  logic          push_ok, pop_ok;
  assign full_o  = cnt_q == (AW+1)'(DEPTH);
  assign empty_o = cnt_q == '0;
  assign push_ok = push_i && !full_o;
  assign pop_ok  = pop_i && !empty_o;
  assign rdata_o = mem_q[rd_q];
  assign count_o = cnt_q;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      wr_q  <= '0;
      rd_q  <= '0;
      cnt_q <= '0;
    end else begin
      if (push_ok) wr_q <= wr_q + 1'b1;
      if (pop_ok) rd_q <= rd_q + 1'b1;
      cnt_q <= cnt_q + (AW+1)'(push_ok) - (AW+1)'(pop_ok);
    end
  always_ff @(posedge clk)
    if (push_ok) mem_q[wr_q] <= wdata_i;
endmodule

// File: rtl/conv_1st_collect.sv
// conv_1st_collect: captures first-layer result sets and streams them out one
// saturated (optionally ReLU'd) lane per handshake with channel/position tags.
module conv_1st_collect import conv_1st_collect_pkg::*; #(
  parameter int LANES = LANES_DEF,
  parameter int DW    = DW_DEF,
  parameter int OW    = OW_DEF,
  parameter int DEPTH = DEPTH_DEF
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 valid_i,
  input  logic [CH_W-1:0]      ch_i,
  input  logic [LANES*DW-1:0]  data_i,
  input  logic                 relu_en,
  output logic                 m_valid,
  input  logic                 m_ready,
  output logic [OW-1:0]        m_data,
  output logic [CH_W-1:0]      m_ch,
  output logic [POS_W-1:0]     m_pos,
  output logic                 m_last,
  output logic                 overflow,
  output logic                 busy
);
  localparam int LW = LANES > 1 ? $clog2(LANES) : 1;
  localparam int EW = LANES*DW + CH_W + POS_W;
  localparam logic signed [DW-1:0] SMAX = DW'((1 << (OW-1)) - 1);
  localparam logic signed [DW-1:0] SMIN = ~SMAX;

  function automatic logic [OW-1:0] post(input logic signed [DW-1:0] v, input logic relu);
    logic signed [DW-1:0] r;
    r = (relu && v < 0) ? '0 : v;
    return r > SMAX ? SMAX[OW-1:0] : r < SMIN ? SMIN[OW-1:0] : r[OW-1:0];
  endfunction

  logic                   push, pop, full, empty, last_acc;
  logic [EW-1:0]          rd;
  logic [$clog2(DEPTH):0] cnt;
  logic [CH_W-1:0]        last_ch_q;
  logic                   have_ch_q, overflow_q;
  logic [POS_W-1:0]       base_q, wbase;
  ser_state_e             state_q;
  logic [LW-1:0]          lane_q, lane_nxt;
  logic [LANES*DW-1:0]    ent_q;
  logic                   m_valid_q, m_last_q;
  logic [OW-1:0]          m_data_q;
  logic [CH_W-1:0]        m_ch_q;
  logic [POS_W-1:0]       m_pos_q;

  // Positions continue across consecutive sets of one channel, restart on a new channel.
  assign wbase    = (have_ch_q && ch_i == last_ch_q) ? base_q + POS_W'(LANES) : '0;
  assign push     = valid_i && !full;
  assign lane_nxt = lane_q + 1'b1;
  assign last_acc = state_q == S_SEND && m_ready && lane_q == LW'(LANES-1);
  assign pop      = !empty && (state_q == S_IDLE || last_acc);

  conv_1st_res_fifo #(.W(EW), .DEPTH(DEPTH)) u_fifo (
    .clk(clk), .rst_n(rst_n), .push_i(push), .pop_i(pop),
    .wdata_i({data_i, ch_i, wbase}), .rdata_o(rd), .count_o(cnt),
    .full_o(full), .empty_o(empty)
  );

  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      last_ch_q  <= '0;
      have_ch_q  <= 1'b0;
      base_q     <= '0;
      overflow_q <= 1'b0;
    end else begin
      if (push) begin
        last_ch_q <= ch_i;
        have_ch_q <= 1'b1;
        base_q    <= wbase;
      end
      if (valid_i && full) overflow_q <= 1'b1;
    end

  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state_q   <= S_IDLE;
      lane_q    <= '0;
      ent_q     <= '0;
      m_valid_q <= 1'b0;
      m_last_q  <= 1'b0;
      m_data_q  <= '0;
      m_ch_q    <= '0;
      m_pos_q   <= '0;
    end else if (pop) begin
      state_q   <= S_SEND;
      lane_q    <= '0;
      ent_q     <= rd[EW-1 -: LANES*DW];
      m_valid_q <= 1'b1;
      m_last_q  <= 1'(LANES == 1);
      m_data_q  <= post(rd[POS_W+CH_W +: DW], relu_en);
      m_ch_q    <= rd[POS_W +: CH_W];
      m_pos_q   <= rd[POS_W-1:0];
    end else if (state_q == S_SEND && m_ready) begin
      if (last_acc) begin
        state_q   <= S_IDLE;
        m_valid_q <= 1'b0;
        m_last_q  <= 1'b0;
      end else begin
        lane_q   <= lane_nxt;
        m_data_q <= post(ent_q[int'(lane_nxt)*DW +: DW], relu_en);
        m_pos_q  <= m_pos_q + 1'b1;
        m_last_q <= lane_nxt == LW'(LANES-1);
      end
    end

  assign m_valid  = m_valid_q;
  assign m_last   = m_last_q;
  assign m_data   = m_data_q;
  assign m_ch     = m_ch_q;
  assign m_pos    = m_pos_q;
  assign overflow = overflow_q;
  assign busy     = cnt != '0 || m_valid_q;
endmodule

// File: tb/tb_conv_1st_collect.sv
// tb_conv_1st_collect: directed and randomized checks of conv_1st_collect against a
// queue-based reference of the samples each accepted set must produce.
module tb_conv_1st_collect;
  logic        clk = 0, rst_n = 0, valid_i = 0, relu_en = 0, m_ready = 0;
  logic [4:0]  ch_i = 0;
  logic [79:0] data_i = 0;
  logic        m_valid, m_last, overflow, busy;
  logic [7:0]  m_data;
  logic [4:0]  m_ch;
  logic [9:0]  m_pos;

  conv_1st_collect dut (
    .clk(clk), .rst_n(rst_n), .valid_i(valid_i), .ch_i(ch_i), .data_i(data_i),
    .relu_en(relu_en), .m_valid(m_valid), .m_ready(m_ready), .m_data(m_data),
    .m_ch(m_ch), .m_pos(m_pos), .m_last(m_last), .overflow(overflow), .busy(busy)
  );

  always #5 clk = ~clk;

  typedef struct {logic [7:0] d; logic [4:0] ch; logic [9:0] pos; logic last;} smp_t;
  smp_t       exp_q[$];
  smp_t       mon_s, prev_s;
  int         tests = 0, fails = 0, mon_cnt = 0;
  bit         hold = 0, m_have = 0;
  logic [4:0] m_chr = 0;
  logic [9:0] m_base = 0;

  function automatic logic [7:0] ref_post(int v, bit relu);
    int r;
    r = (relu && v < 0) ? 0 : v;
    if (r > 127) r = 127;
    if (r < -128) r = -128;
    return 8'(r);
  endfunction

  function automatic int rv();
    return $urandom_range(0, 3) == 0 ? int'($urandom_range(0, 1048575)) - 524288
                                     : int'($urandom_range(0, 1200)) - 600;
  endfunction

  task automatic chk(string tag, logic [31:0] obs, logic [31:0] expv);
    tests++;
    assert (obs === expv) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic pulse(input int v0, v1, v2, v3, input logic [4:0] ch, input bit acc);
    int   v[4];
    smp_t s;
    v[0] = v0; v[1] = v1; v[2] = v2; v[3] = v3;
    valid_i = 1;
    ch_i = ch;
    for (int i = 0; i < 4; i++) data_i[i*20 +: 20] = v[i][19:0];
    if (acc) begin
      m_base = (m_have && ch == m_chr) ? m_base + 10'd4 : 10'd0;
      m_have = 1;
      m_chr = ch;
      for (int i = 0; i < 4; i++) begin
        s.d = ref_post(v[i], relu_en);
        s.ch = ch;
        s.pos = m_base + 10'(i);
        s.last = (i == 3);
        exp_q.push_back(s);
      end
    end
    tick;
    valid_i = 0;
  endtask

  task automatic drain(input bit tog, input int budget);
    int n = 0;
    while ((exp_q.size() != 0 || busy) && n < budget) begin
      if (tog) m_ready = ~m_ready;
      tick;
      n++;
    end
    m_ready = 1;
    chk("drain_queue", exp_q.size(), 0);
    chk("drain_busy", busy, 0);
  endtask

  task automatic model_reset;
    exp_q.delete();
    m_have = 0;
    m_base = 0;
    m_chr = 0;
  endtask

  always @(negedge clk) begin
    if (!rst_n) hold = 0;
    else begin
      if (hold) begin
        chk("hold_valid", m_valid, 1);
        chk("hold_fields", {m_data, m_ch, m_pos, m_last}, {prev_s.d, prev_s.ch, prev_s.pos, prev_s.last});
      end
      hold = m_valid && !m_ready;
      prev_s.d = m_data; prev_s.ch = m_ch; prev_s.pos = m_pos; prev_s.last = m_last;
      if (m_valid && m_ready) begin
        mon_cnt++;
        if (exp_q.size() == 0) begin
          tests++;
          fails++;
          $error("FAIL extra_sample: observed pos %0d ch %0d expected no sample", m_pos, m_ch);
        end else begin
          mon_s = exp_q.pop_front();
          chk("sample_data", m_data, mon_s.d);
          chk("sample_ch", m_ch, mon_s.ch);
          chk("sample_pos", m_pos, mon_s.pos);
          chk("sample_last", m_last, mon_s.last);
        end
      end
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int n, sets, base_cnt;
    m_ready = 1;
    #12;
    chk("rst_valid", m_valid, 0);
    chk("rst_busy", busy, 0);
    chk("rst_ovf", overflow, 0);
    chk("rst_data", m_data, 0);
    chk("rst_pos", m_pos, 0);
    chk("rst_ch", m_ch, 0);
    chk("rst_last", m_last, 0);
    tick;
    rst_n = 1;
    tick;
    pulse(100, -5, 300, -200, 5'd3, 1);
    chk("lat_t1_valid", m_valid, 0);
    tick;
    chk("lat_t2_valid", m_valid, 1);
    chk("lat_t2_data", m_data, 8'd100);
    chk("lat_t2_pos", m_pos, 0);
    tick;
    chk("t3_data", m_data, 8'hFB);
    chk("t3_last", m_last, 0);
    tick;
    chk("t4_data", m_data, 8'h7F);
    tick;
    chk("t5_data", m_data, 8'h80);
    chk("t5_last", m_last, 1);
    drain(0, 50);
    relu_en = 1;
    pulse(100, -5, 300, -200, 5'd3, 1);
    drain(0, 50);
    relu_en = 0;
    pulse(rv(), rv(), rv(), rv(), 5'd7, 1);
    pulse(rv(), rv(), rv(), rv(), 5'd7, 1);
    pulse(rv(), rv(), rv(), rv(), 5'd4, 1);
    drain(0, 60);
    m_ready = 0;
    pulse(rv(), rv(), rv(), rv(), 5'd6, 1);
    pulse(rv(), rv(), rv(), rv(), 5'd6, 1);
    drain(1, 100);
    for (int r = 0; r < 2; r++) begin
      relu_en = r[0];
      repeat (200) begin
        m_ready = $urandom_range(0, 3) != 0;
        if (exp_q.size() <= 12 && $urandom_range(0, 1) == 1)
          pulse(rv(), rv(), rv(), rv(), 5'($urandom_range(0, 2)), 1);
        else tick;
      end
      drain(0, 300);
    end
    relu_en = 0;
    m_ready = 1;
    sets = 0;
    n = 0;
    while (sets < 260 && n < 3000) begin
      if (exp_q.size() <= 12) begin
        pulse(rv(), rv(), rv(), rv(), 5'd9, 1);
        sets++;
      end else tick;
      n++;
    end
    drain(0, 100);
    chk("wrap_sets", sets, 260);
    chk("ovf_clean", overflow, 0);
    m_ready = 0;
    for (int k = 0; k < 6; k++) pulse(rv(), rv(), rv(), rv(), 5'd5, k < 5);
    chk("ovf_set", overflow, 1);
    tick;
    chk("ovf_busy", busy, 1);
    base_cnt = mon_cnt;
    m_ready = 1;
    drain(0, 100);
    chk("ovf_samples", mon_cnt - base_cnt, 20);
    chk("ovf_sticky", overflow, 1);
    pulse(rv(), rv(), rv(), rv(), 5'd2, 1);
    n = 0;
    while (!(m_valid && m_pos == 10'd2) && n < 10) begin
      tick;
      n++;
    end
    chk("mid_lane2", m_pos, 2);
    #2;
    rst_n = 0;
    #1;
    chk("mid_rst_valid", m_valid, 0);
    chk("mid_rst_busy", busy, 0);
    chk("mid_rst_ovf", overflow, 0);
    chk("mid_rst_pos", m_pos, 0);
    model_reset();
    tick;
    rst_n = 1;
    tick;
    pulse(rv(), rv(), rv(), rv(), 5'd2, 1);
    tick;
    chk("post_rst_valid", m_valid, 1);
    chk("post_rst_pos", m_pos, 0);
    drain(0, 50);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/conv_1st_collect.md
CONV_1ST_COLLECT -- requirements
Module: conv_1st_collect

Interface
REQ-001 Parameter LANES, default 4, result lanes delivered per valid_i pulse.
REQ-002 Parameter DW, default 20, signed width of each result lane.
REQ-003 Parameter OW, default 8, signed width of each output sample.
REQ-004 Parameter DEPTH, default 4, capture FIFO entries (power of two).
REQ-005 clk  in  1  clock, all logic on rising edge.
REQ-006 rst_n  in  1  reset, asynchronous, active-low.
REQ-007 valid_i  in  1  one-cycle pulse from the first-layer controller: data_i holds a complete result set.
REQ-008 ch_i  in  5  output-channel (weight matrix) number for the data_i set.
REQ-009 data_i  in  LANES*DW  packed signed results; lane 0 in the LSBs.
REQ-010 relu_en  in  1  quasi-static; 1 = clamp negatives to 0 before saturation.
REQ-011 m_valid  out  1  output sample valid.
REQ-012 m_ready  in  1  downstream accepts the sample.
REQ-013 m_data  out  OW  saturated signed sample.
REQ-014 m_ch  out  5  channel tag of m_data.
REQ-015 m_pos  out  10  position index of m_data within its channel.
REQ-016 m_last  out  1  high on the last lane of a result set.
REQ-017 overflow  out  1  sticky: a valid_i set was dropped.
REQ-018 busy  out  1  FIFO not empty or serializer holding a sample.

Function
REQ-019 Capture: valid_i high and FIFO count < DEPTH writes {data_i, ch_i, base_pos} at that edge; acceptance uses the pre-edge count, ignoring any same-cycle pop.
REQ-020 Drop: valid_i high with count == DEPTH discards the set, leaves base_pos unchanged, and sets overflow.
REQ-021 base_pos: 0 after reset; on each accepted capture, the written value is 0 if ch_i differs from the last accepted channel (or this is the first capture since reset), else previous base_pos + LANES; the 10-bit value wraps modulo 1024.
REQ-022 Serializer states: IDLE and SEND.
- IDLE -> SEND when the FIFO is non-empty: pop the entry and present lane 0.
- SEND: lane index advances on m_valid && m_ready.
- After last-lane acceptance: pop the next entry in the same edge if the FIFO is non-empty (no bubble), else go to IDLE.
REQ-023 Output register: m_data, m_ch, m_pos and m_last are held stable while m_valid && !m_ready; m_valid never drops without acceptance.
REQ-024 m_pos equals entry base_pos + lane index; m_last equals (lane index == LANES-1).
REQ-025 Post-processing per lane: if relu_en and value < 0, value becomes 0; result is then saturated to [-2^(OW-1), 2^(OW-1)-1].
REQ-026 Latency: with FIFO empty and serializer IDLE, valid_i in cycle t gives m_valid high in cycle t+2 with lane 0.
REQ-027 Throughput: one sample per cycle while m_ready is held high; one entry drains in LANES cycles.
REQ-028 A capture and a pop in the same cycle leave the count unchanged; FIFO pointers wrap modulo DEPTH.

Reset
REQ-029 Asserting rst_n low at any time, including mid-set, immediately clears:
- m_valid, m_last, overflow and busy to 0;
- m_data, m_ch and m_pos to 0;
- FIFO count and pointers, base_pos and the last-channel record;
- state to IDLE.
REQ-030 A partially sent set is discarded on reset and is not resumed.

Structure
REQ-031 LANES, DW, OW, DEPTH defaults and the 5-bit channel / 10-bit position widths reside in the shared first-layer conv package.
REQ-032 The capture FIFO is one sub-module, conv_1st_res_fifo (synchronous push/pop, count, full/empty); the serializer and saturation logic stay in conv_1st_collect.

Verification
REQ-033 One set [100, -5, 300, -200], ch 3, relu_en=0, m_ready=1 -> four samples in cycles t+2..t+5: 100, -5, 127, -128; m_pos 0..3; m_ch 3; m_last on the 4th sample only.
REQ-034 Same set with relu_en=1 -> samples 100, 0, 127, 0.
REQ-035 Two sets on ch 3, then one set on ch 4 -> m_pos runs 0-3, then 4-7, then 0-3 with m_ch 4.
REQ-036 m_ready=0, then six valid_i pulses -> first five are captured (four in the FIFO plus one in the serializer), the sixth is dropped with overflow=1; after release exactly 20 samples emerge in order and overflow stays 1.
REQ-037 m_ready toggling every cycle -> each sample is held stable until accepted, with no duplicated or skipped positions.
REQ-038 rst_n pulsed low during lane 2 of a set -> m_valid, busy and overflow drop immediately; the next set after reset starts at m_pos 0.
